// File: rtl/display_arbiter.sv
// display_arbiter
//
// Shares the four-digit hex display between a background value and two
// prioritised, timed messages. Requester 1 outranks requester 0 and may cut
// a requester-0 message short; a message otherwise stays on screen for
// HOLD_CYCLES cycles and then hands back to the background (or straight to
// the next pending message). cancel returns to the background at once.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   base_value  background display content (shown while no message is active)
//   req[1:0]    level requests, held until ack
//   msg0, msg1  message content, sampled only on the accept edge
//   cancel      abort any active message, back to background
//   ack[1:0]    one-cycle pulse when message i is accepted
//   done[1:0]   one-cycle pulse when message i expires normally
//   owner[1:0]  00 background, 01 msg0, 10 msg1
//   value[15:0] registered display value {d3,d2,d1,d0}
module display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] base_value,
  input  logic [1:0]  req,
  input  logic [15:0] msg0,
  input  logic [15:0] msg1,
  input  logic        cancel,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic [1:0]  owner,
  output logic [15:0] value
);

  // Encoding chosen so the state register doubles as the owner output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW0 = 2'b01,
    SHOW1 = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [15:0]       value_reg, value_next;
  logic [1:0]        ack_reg, ack_next;
  logic [1:0]        done_reg, done_next;
  logic              expired;
  logic              take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      value_reg <= 16'h0000;
      ack_reg   <= 2'b00;
      done_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      value_reg <= value_next;
      ack_reg   <= ack_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    value_next = value_reg;
    ack_next   = 2'b00;
    done_next  = 2'b00;

    // Last cycle of the hold window for the message currently shown.
    expired = (state_reg != IDLE) && (cnt_reg == LAST);

    // A new message may be taken from idle, at normal expiry (back-to-back
    // hand-over), or when requester 1 preempts a requester-0 message.
    take = (state_reg == IDLE) || expired || ((state_reg == SHOW0) && req[1]);

    if (cancel) begin
      // Cancel overrides everything, including a request seen this cycle.
      state_next = IDLE;
      cnt_next   = '0;
      value_next = base_value;
    end else begin
      if (expired) begin
        done_next = (state_reg == SHOW1) ? 2'b10 : 2'b01;
      end

      if (take && req[1]) begin
        state_next = SHOW1;
        cnt_next   = '0;
        value_next = msg1;
        ack_next   = 2'b10;
      end else if (take && req[0]) begin
        state_next = SHOW0;
        cnt_next   = '0;
        value_next = msg0;
        ack_next   = 2'b01;
      end else if (take) begin
        // Idle with nothing pending, or expiry with nothing pending.
        state_next = IDLE;
        cnt_next   = '0;
        value_next = base_value;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ack   = ack_reg;
  assign done  = done_reg;
  assign owner = state_reg;
  assign value = value_reg;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] base_value;
  logic [1:0]  req;
  logic [15:0] msg0;
  logic [15:0] msg1;
  logic        cancel;
  logic [1:0]  ack;
  logic [1:0]  done;
  logic [1:0]  owner;
  logic [15:0] value;

  int n_cmp = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference model: who is on screen (-1 = background), how many more
  // cycles the current message still has, and what the screen shows.
  int          m_cur;
  int          m_left;
  logic [15:0] m_shown;

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .base_value(base_value),
    .req(req),
    .msg0(msg0),
    .msg1(msg1),
    .cancel(cancel),
    .ack(ack),
    .done(done),
    .owner(owner),
    .value(value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, advance
  // the model from the rules, then compare all outputs just after the edge.
  task automatic step(input logic [1:0] r, input logic c, input logic [15:0] m0,
                      input logic [15:0] m1, input logic [15:0] b);
    logic [1:0] e_ack;
    logic [1:0] e_done;
    logic [1:0] e_owner;
    int         want;
    bit         finished;
    bit         free;
    req = r; cancel = c; msg0 = m0; msg1 = m1; base_value = b;
    @(posedge clk);
    e_ack = 2'b00;
    e_done = 2'b00;
    if (c) begin
      m_cur = -1;
      m_shown = b;
    end else begin
      finished = (m_cur >= 0) && (m_left == 1);
      if (finished) e_done[m_cur] = 1'b1;
      want = r[1] ? 1 : (r[0] ? 0 : -1);
      free = (m_cur < 0) || finished || (m_cur == 0 && want == 1);
      if (free && want >= 0) begin
        e_ack[want] = 1'b1;
        m_cur = want;
        m_left = HOLD;
        m_shown = (want == 1) ? m1 : m0;
      end else if (free) begin
        m_cur = -1;
        m_shown = b;
      end else begin
        m_left--;
      end
    end
    e_owner = (m_cur == 1) ? 2'b10 : (m_cur == 0 ? 2'b01 : 2'b00);
    #1;
    n_step++;
    $display("step %0d req=%b cancel=%b ack=%b done=%b owner=%b value=%h",
             n_step, r, c, ack, done, owner, value);
    check("ack", {30'd0, ack}, {30'd0, e_ack});
    check("done", {30'd0, done}, {30'd0, e_done});
    check("owner", {30'd0, owner}, {30'd0, e_owner});
    check("value", {16'd0, value}, {16'd0, m_shown});
    @(negedge clk);
  endtask

  // Called at a negedge: asynchronous reset mid-cycle, hold over one edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_value", {16'd0, value}, 32'h0);
    check("rst_owner", {30'd0, owner}, 32'h0);
    check("rst_ack", {30'd0, ack}, 32'h0);
    check("rst_done", {30'd0, done}, 32'h0);
    m_cur = -1;
    m_shown = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 2'b00; cancel = 1'b0; msg0 = 16'h0; msg1 = 16'h0; base_value = 16'h1234;
    m_cur = -1; m_left = 0; m_shown = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("por_value", {16'd0, value}, 32'h0);
    check("por_owner", {30'd0, owner}, 32'h0);
    rst_n = 1'b1;

    // Reset and background
    step(2'b00, 1'b0, 16'h0, 16'h0, 16'h1234);
    step(2'b00, 1'b0, 16'h0, 16'h0, 16'h1234);

    // Single message, request dropped after ack
    step(2'b01, 1'b0, 16'hABCD, 16'h0, 16'h1234);
    for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 16'h5555, 16'h0, 16'h1234);

    // Simultaneous requests, req[0] kept until its ack on msg1 expiry
    step(2'b11, 1'b0, 16'hA000, 16'hB111, 16'h2222);
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 16'hA000, 16'hFFFF, 16'h2222);
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 16'h0, 16'h0, 16'h2222);

    // Preemption in the second cycle of msg0
    step(2'b01, 1'b0, 16'hC0C0, 16'h0, 16'h3333);
    step(2'b00, 1'b0, 16'h0, 16'h0, 16'h3333);
    step(2'b10, 1'b0, 16'h0, 16'hD1D1, 16'h3333);
    for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 16'h0, 16'h0, 16'h3333);

    // Cancel together with a request during msg1
    step(2'b10, 1'b0, 16'h0, 16'hE1E1, 16'h4444);
    step(2'b00, 1'b0, 16'h0, 16'h0, 16'h4444);
    step(2'b01, 1'b1, 16'hF0F0, 16'h0, 16'h4545);
    step(2'b01, 1'b0, 16'hF0F0, 16'h0, 16'h4545);
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 16'h0, 16'h0, 16'h4545);

    // Reset in the middle of msg0
    step(2'b01, 1'b0, 16'h6060, 16'h0, 16'h7777);
    step(2'b00, 1'b0, 16'h0, 16'h0, 16'h7777);
    do_reset();
    for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 16'h0, 16'h0, 16'h7777);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] r;
      logic       c;
      r[0] = ($urandom_range(0, 4) == 0);
      r[1] = ($urandom_range(0, 6) == 0);
      c    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 119) == 0) do_reset();
      step(r, c, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the four-digit hex display between a background source and two prioritised message requesters. It registers the 16-bit value that feeds the display driver's `value` input, which is four nibbles `{d3,d2,d1,d0}`. It also sequences timed message windows: accept, hold for a fixed number of cycles, then return to the background. The game top uses it so that the score is shown by default, while "HIT"/"MISS" codes (requester 0) and the "GAME OVER" code (requester 1) override it temporarily.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: clock cycles a message stays on screen (1 s at 50 MHz). Must be ≥ 1.
- `CNT_W`, default `$clog2(HOLD_CYCLES+1)`: width of the hold counter.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `base_value`  in  16: background content, shown whenever no message is active.
- `req`  in  2: level request per requester; held high by the requester until `ack`.
- `msg0`  in  16: requester 0 message content; sampled on the accept edge only.
- `msg1`  in  16: requester 1 message content; sampled on the accept edge only.
- `cancel`  in  1: abort any active message and return to the background.
- `ack`  out  2: one-cycle pulse, `ack[i]` set in the cycle message i is accepted.
- `done`  out  2: one-cycle pulse on normal expiry of message i.
- `owner`  out  2: 2'b00 background, 2'b01 msg0, 2'b10 msg1.
- `value`  out  16: registered display value.

## Operation
States:
- **IDLE**: `value` ← `base_value` every cycle; `owner` = 00.
- **SHOW0**: shows the latched `msg0`; `owner` = 01.
- **SHOW1**: shows the latched `msg1`; `owner` = 10.

Priority and acceptance:
- Priority is `req[1]` > `req[0]`.
- In IDLE, if any request is high, accept the highest. On that edge: latch its msg into `value`, clear the counter, pulse `ack[i]`, enter SHOWi.

Preemption:
- In SHOW0, `req[1]` preempts immediately with the same accept actions.
- The preempted message gets no `done` and is not resumed.
- `req[0]` during SHOW0 or SHOW1 waits.

Expiry:
- The counter increments each cycle in SHOWi.
- When the counter = HOLD_CYCLES-1, pulse `done[i]` on the next edge.
- If a request is pending on that cycle, accept it directly (back-to-back, no IDLE cycle): `done[i]` and `ack[j]` pulse together.
- Otherwise go to IDLE.

Cancel:
- `cancel` has the highest precedence. In any state: go to IDLE, load `value` ← `base_value`, no `done`, no `ack` that cycle, even if `req` is high.
- Pending requests are accepted from the next cycle.

Other rules:
- Latched message content is immune to later `msg*` changes.
- `base_value` changes during SHOWi have no effect until IDLE.
- Counter saturation never occurs: the counter is cleared on every accept and on every exit.
- Requests that deassert before ack are simply dropped; no memory of past requests.

## Timing
- Reset values: `value` = 16'h0000, `owner` = 00, `ack` = 00, `done` = 00, state IDLE, counter 0. Reset mid-message aborts with no `done`.
- All outputs are registered. Background path latency is 1 cycle (`base_value` to `value`).
- Accept latency is 1 cycle: `req` sampled high at edge N gives `ack`, `value` = msg and `owner` valid after edge N.
- Message window: `value` holds the msg for exactly HOLD_CYCLES cycles, then `base_value` (or the next msg) appears on the following edge, in the same cycle as `done`.
- Requester obligation: drop `req[i]` in the cycle after seeing `ack[i]`. A `req` still high after ack is treated as a new request once re-eligible.

## Test plan
All scenarios use `HOLD_CYCLES`=4.

1. **Reset and background**: reset, then `base_value`=16'h1234 → `value`=16'h0000 during reset; 16'h1234 one cycle after release; `owner`=00.
2. **Single message**: `req`=01 with `msg0`=16'hABCD (req dropped on ack) → `ack`=01 one cycle later; `value`=ABCD for 4 cycles; `done`=01 with `value` back to `base_value`.
3. **Simultaneous requests**: `req`=11 in IDLE → `ack`=10, msg1 shown. `req[0]` stays high, so on msg1 expiry `done`=10 and `ack`=01 pulse in the same cycle, and msg0 is shown with no IDLE gap.
4. **Preemption**: `req[1]` asserted during cycle 2 of SHOW0 → `ack`=10 next cycle, `owner`=10, no `done[0]` ever; msg1 shown for 4 full cycles.
5. **Cancel vs. request**: `cancel`=1 and `req`=01 in the same cycle during SHOW1 → IDLE, `value`=`base_value`, no `ack`/`done` that cycle; `ack`=01 on the following cycle.
6. **Mid-message reset**: assert `rst_n`=0 during SHOW0 → `value`=0 and `owner`=00 immediately (async); no `done` pulses after release.
